// File: rtl/arashi_thread_cache_mc_pkg.sv
// Shared widths and per-channel status type for the multi-channel thread cache.
package arashi_thread_cache_pkg;

   // Upper bound on level width carried in the status struct.
   localparam int unsigned MAX_LVL_W = 16;

   // Channel-index width; at least one bit even for a single channel.
   function automatic int unsigned ch_w(input int unsigned num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // Occupancy width able to represent 0..depth inclusive.
   function automatic int unsigned lvl_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic [MAX_LVL_W-1:0] level;
      logic                 last_id;
      logic                 avail;
   } ch_status_t;

endpackage

// File: rtl/arashi_thread_cache_mc_if.sv
// Write/read bus of the multi-channel thread cache.
interface arashi_thread_cache_mc_if
   import arashi_thread_cache_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned NUM_CH     = 2
);
   localparam int unsigned CH_W  = ch_w(NUM_CH);
   localparam int unsigned LVL_W = lvl_w(DEPTH);

   logic [NUM_CH-1:0]            w_ena;
   logic [NUM_CH-1:0]            w_id;
   logic [NUM_CH*DATA_WIDTH-1:0] data_in;
   logic [NUM_CH-1:0]            w_ready;
   logic                         r_ena;
   logic [DATA_WIDTH-1:0]        data_out;
   logic                         data_valid;
   logic [CH_W-1:0]              data_ch;
   logic [NUM_CH*LVL_W-1:0]      level;
   logic [NUM_CH-1:0]            avail;
   logic                         avail_any;

   modport master (
      output w_ena, w_id, data_in, r_ena,
      input  w_ready, data_out, data_valid, data_ch, level, avail, avail_any
   );

   modport slave (
      input  w_ena, w_id, data_in, r_ena,
      output w_ready, data_out, data_valid, data_ch, level, avail, avail_any
   );

endinterface

// File: rtl/arashi_thread_cache_fifo.sv
// One toggle-handshake write queue with occupancy and lookahead availability.
module arashi_thread_cache_fifo
   import arashi_thread_cache_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  w_ena,
   input  logic                  w_id,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  r_ena,
   input  logic                  grant,
   output logic                  w_ready,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  nonempty,
   output ch_status_t            status
);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;
   localparam int unsigned LVL_W = lvl_w(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  last_id_q, last_id_d;
   logic                  w_ready_q, w_ready_d;
   logic                  accept;
   logic                  avail;

   // Accept decision, storage/pointer/level next state and lookahead flag.
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      last_id_d = last_id_q;
      accept    = w_ena & (w_id != last_id_q) & (level_q < LVL_W'(DEPTH));
      w_ready_d = accept;
      if (accept) begin
         mem_d[wr_ptr_q[IDX_W-1:0]] = w_data;
         wr_ptr_d                   = wr_ptr_q + 1'b1;
         last_id_d                  = w_id;
      end
      if (grant) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      level_d = level_q + LVL_W'(accept) - LVL_W'(grant);
      if (level_q == '0) begin
         avail = accept;
      end else if (level_q == LVL_W'(1)) begin
         avail = ~(r_ena & grant);
      end else begin
         avail = 1'b1;
      end
   end

   // State registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         last_id_q <= 1'b0;
         w_ready_q <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         last_id_q <= last_id_d;
         w_ready_q <= w_ready_d;
      end
   end

   assign w_ready        = w_ready_q;
   assign head           = mem_q[rd_ptr_q[IDX_W-1:0]];
   assign nonempty       = (wr_ptr_q != rd_ptr_q);
   assign status.level   = MAX_LVL_W'(level_q);
   assign status.last_id = last_id_q;
   assign status.avail   = avail;

endmodule

// File: rtl/arashi_thread_cache_mc.sv
// Multi-channel thread cache: per-channel queues drained by one round-robin read port.
module arashi_thread_cache_mc
   import arashi_thread_cache_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned NUM_CH     = 2
) (
   input logic                    clk,
   input logic                    rstn,
   arashi_thread_cache_mc_if.slave bus
);
   localparam int unsigned CH_W  = ch_w(NUM_CH);
   localparam int unsigned LVL_W = lvl_w(DEPTH);

   logic [DATA_WIDTH-1:0] head [NUM_CH];
   ch_status_t            status [NUM_CH];
   logic [NUM_CH-1:0]     nonempty;
   logic [NUM_CH-1:0]     grant_vec;
   logic [NUM_CH-1:0]     avail_vec;
   logic                  grant_found;
   logic [CH_W-1:0]       grant_ch;
   int unsigned           cand;

   logic [CH_W-1:0]       rr_q, rr_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  data_valid_q, data_valid_d;
   logic [CH_W-1:0]       data_ch_q, data_ch_d;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic ch_unused;

      arashi_thread_cache_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH)
      ) u_fifo (
         .clk      (clk),
         .rstn     (rstn),
         .w_ena    (bus.w_ena[c]),
         .w_id     (bus.w_id[c]),
         .w_data   (bus.data_in[c*DATA_WIDTH +: DATA_WIDTH]),
         .r_ena    (bus.r_ena),
         .grant    (grant_vec[c]),
         .w_ready  (bus.w_ready[c]),
         .head     (head[c]),
         .nonempty (nonempty[c]),
         .status   (status[c])
      );

      assign bus.level[c*LVL_W +: LVL_W] = status[c].level[LVL_W-1:0];
      assign avail_vec[c]                = status[c].avail;
      assign ch_unused = ^{status[c].level[MAX_LVL_W-1:LVL_W], status[c].last_id};
   end

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      grant_found = 1'b0;
      grant_ch    = rr_q;
      grant_vec   = '0;
      cand        = 0;
      if (bus.r_ena) begin
         for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = (32'(rr_q) + i) % NUM_CH;
            if (!grant_found && nonempty[CH_W'(cand)]) begin
               grant_found = 1'b1;
               grant_ch    = CH_W'(cand);
            end
         end
      end
      if (grant_found) begin
         grant_vec[grant_ch] = 1'b1;
      end
   end

   // Read-port output and round-robin pointer next state.
   always_comb begin
      data_out_d   = grant_found ? head[grant_ch] : '0;
      data_valid_d = grant_found;
      data_ch_d    = grant_found ? grant_ch : data_ch_q;
      rr_d         = grant_found ? grant_ch : rr_q;
   end

   // Output registers; RR pointer resets to the last channel so channel 0 wins first.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rr_q         <= CH_W'(NUM_CH - 1);
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         data_ch_q    <= '0;
      end else begin
         rr_q         <= rr_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         data_ch_q    <= data_ch_d;
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.data_ch    = data_ch_q;
   assign bus.avail      = avail_vec;
   assign bus.avail_any  = |avail_vec;

endmodule

// File: tb/tb_arashi_thread_cache_mc.sv
// Self-checking bench: directed table, corner sequences and random traffic vs a queue model.
module tb_arashi_thread_cache_mc;
   import arashi_thread_cache_pkg::*;

   localparam int unsigned DW     = 32;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned NUM_CH = 2;
   localparam int unsigned LVL_W  = lvl_w(DEPTH);

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   arashi_thread_cache_mc_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) bus ();

   arashi_thread_cache_mc #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: one queue per channel plus last ids and RR position.
   typedef logic [DW-1:0] dq_t [$];
   dq_t               mq [NUM_CH];
   logic [NUM_CH-1:0] m_last;
   logic [NUM_CH-1:0] m_wready;
   logic [DW-1:0]     m_dout;
   logic              m_valid;
   int                m_ch;
   int                m_rr;

   typedef struct {
      logic [1:0]  we;
      logic [1:0]  wid;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        r;
      logic [1:0]  x_wr;
      logic        x_v;
      logic [31:0] x_d;
      logic        x_ch;
      logic [2:0]  x_l0;
      logic [2:0]  x_l1;
   } vec_t;
   vec_t tbl [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int find_grant();
      int c;
      if (!bus.r_ena) return -1;
      for (int i = 1; i <= NUM_CH; i++) begin
         c = (m_rr + i) % NUM_CH;
         if (mq[c].size() > 0) return c;
      end
      return -1;
   endfunction

   task automatic set_in(input logic [1:0] we, input logic [1:0] wid,
                         input logic [31:0] d0, input logic [31:0] d1, input logic r);
      bus.w_ena   = we;
      bus.w_id    = wid;
      bus.data_in = {d1, d0};
      bus.r_ena   = r;
   endtask

   // One clock: check lookahead before the edge, advance model, check registers after.
   task automatic step(input bit chk_model);
      int                   g;
      logic [NUM_CH-1:0]    acc;
      logic [NUM_CH-1:0]    exp_av;
      logic [NUM_CH-1:0]    wid_s;
      logic [NUM_CH*DW-1:0] din_s;
      #2;
      g     = find_grant();
      wid_s = bus.w_id;
      din_s = bus.data_in;
      for (int c = 0; c < NUM_CH; c++) begin
         acc[c] = bus.w_ena[c] && (wid_s[c] != m_last[c]) && (mq[c].size() < DEPTH);
         if (mq[c].size() == 0)      exp_av[c] = acc[c];
         else if (mq[c].size() == 1) exp_av[c] = (g != c);
         else                        exp_av[c] = 1'b1;
      end
      if (chk_model) begin
         chk("avail", 64'(bus.avail), 64'(exp_av));
         chk("avail_any", 64'(bus.avail_any), 64'(|exp_av));
      end
      @(posedge clk);
      #1;
      if (!rstn) begin
         for (int c = 0; c < NUM_CH; c++) mq[c].delete();
         m_last = '0; m_wready = '0; m_dout = '0; m_valid = 1'b0; m_ch = 0; m_rr = NUM_CH - 1;
      end else begin
         if (g >= 0) begin
            m_dout = mq[g].pop_front(); m_valid = 1'b1; m_ch = g; m_rr = g;
         end else begin
            m_dout = '0; m_valid = 1'b0;
         end
         for (int c = 0; c < NUM_CH; c++) begin
            m_wready[c] = acc[c];
            if (acc[c]) begin
               mq[c].push_back(din_s[c*DW +: DW]);
               m_last[c] = wid_s[c];
            end
         end
      end
      if (chk_model) begin
         chk("w_ready", 64'(bus.w_ready), 64'(m_wready));
         chk("data_valid", 64'(bus.data_valid), 64'(m_valid));
         chk("data_out", 64'(bus.data_out), 64'(m_dout));
         chk("data_ch", 64'(bus.data_ch), 64'(m_ch));
         for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("level%0d", c), 64'(bus.level[c*LVL_W +: LVL_W]), 64'(mq[c].size()));
      end
   endtask

   // Single write with a fresh toggle id on channel c.
   task automatic wr1(input int c, input logic [31:0] d);
      logic [1:0]  we, wid;
      logic [63:0] din;
      we  = '0;
      we[c] = 1'b1;
      wid = m_last;
      wid[c] = ~m_last[c];
      din = '0;
      din[c*DW +: DW] = d;
      set_in(we, wid, din[31:0], din[63:32], 1'b0);
      step(1);
   endtask

   initial begin
      logic [31:0] rr_d [4];
      logic        rr_c [4];

      tbl[0]  = '{2'b01, 2'b01, 32'hA1, 32'h0,  1'b0, 2'b01, 1'b0, 32'h0,  1'b0, 3'd1, 3'd0};
      tbl[1]  = '{2'b01, 2'b00, 32'hA2, 32'h0,  1'b0, 2'b01, 1'b0, 32'h0,  1'b0, 3'd2, 3'd0};
      tbl[2]  = '{2'b01, 2'b00, 32'hA3, 32'h0,  1'b0, 2'b00, 1'b0, 32'h0,  1'b0, 3'd2, 3'd0};
      tbl[3]  = '{2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 2'b00, 1'b1, 32'hA1, 1'b0, 3'd1, 3'd0};
      tbl[4]  = '{2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 2'b00, 1'b1, 32'hA2, 1'b0, 3'd0, 3'd0};
      tbl[5]  = '{2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 2'b00, 1'b0, 32'h0,  1'b0, 3'd0, 3'd0};
      tbl[6]  = '{2'b10, 2'b10, 32'h0,  32'hB1, 1'b0, 2'b10, 1'b0, 32'h0,  1'b0, 3'd0, 3'd1};
      tbl[7]  = '{2'b10, 2'b00, 32'h0,  32'hB2, 1'b0, 2'b10, 1'b0, 32'h0,  1'b0, 3'd0, 3'd2};
      tbl[8]  = '{2'b10, 2'b10, 32'h0,  32'hB3, 1'b0, 2'b10, 1'b0, 32'h0,  1'b0, 3'd0, 3'd3};
      tbl[9]  = '{2'b10, 2'b00, 32'h0,  32'hB4, 1'b0, 2'b10, 1'b0, 32'h0,  1'b0, 3'd0, 3'd4};
      tbl[10] = '{2'b10, 2'b10, 32'h0,  32'hB5, 1'b0, 2'b00, 1'b0, 32'h0,  1'b0, 3'd0, 3'd4};
      tbl[11] = '{2'b10, 2'b10, 32'h0,  32'hB5, 1'b1, 2'b00, 1'b1, 32'hB1, 1'b1, 3'd0, 3'd3};
      tbl[12] = '{2'b10, 2'b10, 32'h0,  32'hB5, 1'b0, 2'b10, 1'b0, 32'h0,  1'b1, 3'd0, 3'd4};

      // Reset with writes requested: everything must stay cleared.
      rstn = 1'b0;
      set_in(2'b11, 2'b11, 32'h11, 32'h22, 1'b1);
      step(0);
      step(1);
      chk("rst_w_ready", 64'(bus.w_ready), 64'h0);
      chk("rst_data_out", 64'(bus.data_out), 64'h0);
      chk("rst_data_valid", 64'(bus.data_valid), 64'h0);
      chk("rst_data_ch", 64'(bus.data_ch), 64'h0);
      chk("rst_level", 64'(bus.level), 64'h0);

      // Directed table: single channel, repeated id, full channel.
      rstn = 1'b1;
      for (int i = 0; i < 13; i++) begin
         set_in(tbl[i].we, tbl[i].wid, tbl[i].d0, tbl[i].d1, tbl[i].r);
         step(0);
         chk($sformatf("tbl%0d_w_ready", i), 64'(bus.w_ready), 64'(tbl[i].x_wr));
         chk($sformatf("tbl%0d_valid", i), 64'(bus.data_valid), 64'(tbl[i].x_v));
         chk($sformatf("tbl%0d_dout", i), 64'(bus.data_out), 64'(tbl[i].x_d));
         chk($sformatf("tbl%0d_ch", i), 64'(bus.data_ch), 64'(tbl[i].x_ch));
         chk($sformatf("tbl%0d_lvl0", i), 64'(bus.level[0 +: LVL_W]), 64'(tbl[i].x_l0));
         chk($sformatf("tbl%0d_lvl1", i), 64'(bus.level[LVL_W +: LVL_W]), 64'(tbl[i].x_l1));
      end

      // Drain channel 1 completely.
      set_in(2'b00, m_last, 32'h0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) step(1);

      // Round robin: ch0={1,2}, ch1={3,4} drains as 1,3,2,4.
      wr1(0, 32'd1); wr1(0, 32'd2); wr1(1, 32'd3); wr1(1, 32'd4);
      rr_d = '{32'd1, 32'd3, 32'd2, 32'd4};
      rr_c = '{1'b0, 1'b1, 1'b0, 1'b1};
      set_in(2'b00, m_last, 32'h0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk($sformatf("rr%0d_dout", i), 64'(bus.data_out), 64'(rr_d[i]));
         chk($sformatf("rr%0d_ch", i), 64'(bus.data_ch), 64'(rr_c[i]));
      end
      step(1);
      chk("rr_end_valid", 64'(bus.data_valid), 64'h0);
      chk("rr_end_dout", 64'(bus.data_out), 64'h0);

      // Lookahead: last entry being read, then empty channel with a fresh write.
      wr1(0, 32'h55);
      set_in(2'b00, m_last, 32'h0, 32'h0, 1'b1);
      #2;
      chk("look_lvl1_read", 64'(bus.avail[0]), 64'h0);
      step(1);
      set_in(2'b01, {m_last[1], ~m_last[0]}, 32'h66, 32'h0, 1'b0);
      #2;
      chk("look_lvl0_write", 64'(bus.avail[0]), 64'h1);
      step(1);

      // Reset mid-stream with a read pending; nothing stale may come out afterwards.
      wr1(0, 32'h77); wr1(0, 32'h88);
      rstn = 1'b0;
      set_in(2'b00, m_last, 32'h0, 32'h0, 1'b1);
      step(1);
      chk("mid_rst_level", 64'(bus.level), 64'h0);
      chk("mid_rst_valid", 64'(bus.data_valid), 64'h0);
      rstn = 1'b1;
      set_in(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
      step(1);
      chk("post_rst_valid", 64'(bus.data_valid), 64'h0);
      chk("post_rst_dout", 64'(bus.data_out), 64'h0);

      // Randomized traffic against the model, with occasional resets.
      for (int n = 0; n < 400; n++) begin
         logic [1:0] wid;
         rstn = ($urandom_range(99) != 0);
         for (int c = 0; c < NUM_CH; c++)
            wid[c] = ($urandom_range(1) != 0) ? ~m_last[c] : m_last[c];
         set_in(2'($urandom_range(3)), wid, $urandom, $urandom, 1'($urandom_range(1)));
         step(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
